sys_mem_responder: RTL and testbench
====================================

Name: sys_mem_responder

Overview:
- Responder (memory side) of the Sys bus that the cache controller drives as initiator.
- Accepts single-word write-through requests and block-refill read requests.
- Inserts programmable wait states and streams a refill block as consecutive SysReady-qualified beats, matching the cache's beat counter.
- Holds a synchronous word-addressed memory array; serves as the system memory model and as the basis for the real memory controller.

Parameters:
- MEM_AW, 10, word-address width of the backing array (2**MEM_AW 32-bit words).
- WAIT_STATES, 2, idle cycles inserted before every data beat or write acknowledge; 0 is legal.
- OFS_W, 4, block offset width; refill burst length = 2**OFS_W words (16).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- SysStrobe  input  1  request strobe from the cache, one-cycle pulse.
- SysRW  input  1  1 = read (block refill), 0 = write (single word).
- SysAddress  input  32  byte address; held stable by the initiator until its transaction completes.
- SysData_in  input  32  write data from the cache.
- SysData_out  output  32  read beat data, valid only while SysReady = 1.
- SysReady  output  1  one-cycle beat / acknowledge pulse.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; SysReady = 0; SysData_out = 0; internal counters = 0.
  - Memory array contents are not cleared.
  - Reset mid-transaction abandons it; no partial write is committed unless its write cycle already occurred.
- State machine: IDLE, WAIT, BEAT.
- IDLE:
  - SysStrobe = 1 latches SysRW, SysAddress[MEM_AW+1:2] and SysData_in.
  - Wait counter loads WAIT_STATES and beat counter clears.
  - Next state: WAIT, or BEAT directly if WAIT_STATES = 0.
- WAIT:
  - Decrement the wait counter; go to BEAT when it reaches 1 (exactly WAIT_STATES cycles spent in WAIT).
  - SysStrobe is ignored.
- BEAT, read:
  - SysReady = 1; SysData_out = mem[{latched_addr[MEM_AW-1:OFS_W], beat_cnt}].
  - Beats always start at offset 0 of the block, regardless of the low address bits.
  - Beat counter increments. If it was 2**OFS_W-1, go to IDLE; otherwise reload the wait counter and go to WAIT (or stay in BEAT if WAIT_STATES = 0).
- BEAT, write:
  - SysReady = 1; mem[latched_addr] <= latched data on this edge; go to IDLE.
  - SysData_out stays 0.
- Latency, with request strobed at cycle 0:
  - Read beat k (k = 0..15) asserts SysReady at cycle (k+1)*(WAIT_STATES+1).
  - Write acknowledge at cycle WAIT_STATES+1.
  - With defaults: read beats at 3, 6, …, 48; write ack at 3.
- Memory read is registered: the read address is presented one cycle before the BEAT cycle, so data is valid combinationally-free in BEAT.
- Turnaround:
  - A strobe coinciding with the final SysReady cycle is ignored.
  - A new request is accepted in IDLE no earlier than the cycle after the final SysReady.
- SysStrobe while not in IDLE is ignored; no queuing.
- Address bits above MEM_AW+1 are ignored, so addresses alias modulo the array size. SysAddress[1:0] are ignored.
- SysData_out = 0 in every cycle where SysReady = 0.
- Read after write:
  - A read issued after a write's acknowledge returns the new data.
  - No bypass is needed, because requests never overlap.

Decomposition:
- Shared package / include holds:
  - RW_READ = 1'b1 and RW_WRITE = 1'b0, identical to the cache side.
  - The state encoding (IDLE, WAIT, BEAT; 2 bits).
  - The default WAITSTATE value, 2.
- One natural sub-module: sys_mem_array, a single-port synchronous 32-bit RAM (clock, we, addr[MEM_AW-1:0], wdata, rdata).
- The FSM, wait counter and beat counter stay in sys_mem_responder.

Test Plan:
- Reset: hold reset = 0 for 3 cycles mid-read-burst, then release → SysReady = 0 and SysData_out = 0 immediately; the next strobe is accepted normally from IDLE.
- Write then read: write 0xDEADBEEF to 0x0000_0048; ack at cycle 3. Then read 0x0000_0040 → 16 beats at cycles 3, 6, …, 48; beat 2 carries 0xDEADBEEF.
- Block alignment: fill words 0x100..0x13C with their own address, then read strobe at 0x0000_0124 → beats return 0x100, 0x104, …, 0x13C in order, starting at offset 0.
- WAIT_STATES = 0: read burst → SysReady high for 16 consecutive cycles (1..16); write ack at cycle 1.
- Busy-strobe ignore: pulse SysStrobe (write, different address) during read beat 5 → no extra SysReady, target word unchanged, burst completes with exactly 16 beats.
- Aliasing and turnaround: write 0x11111111 to 0x0000_1008 (MEM_AW = 10), then strobe a read of 0x0000_0000 on the cycle after the ack → accepted; beat 2 = 0x11111111.

Source files
------------

// File: rtl/sys_mem_responder_pkg.sv
// sys_mem_responder_pkg: definitions shared by the Sys bus memory responder and
// its backing array.
//   - Sys bus direction encoding (must match the cache-side initiator).
//   - Responder FSM state encoding.
//   - Default wait-state count and a counter-width helper.
package sys_mem_responder_pkg;

  // SysRW encoding, identical to the cache controller's view of the bus.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Responder FSM states (2-bit encoding).
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StBeat = 2'd2;

  // Default number of idle cycles inserted ahead of each beat / acknowledge.
  localparam int unsigned WAITSTATE = 2;

  // Sys bus data width.
  localparam int unsigned SYS_DW = 32;

  // Width of a down-counter that must hold max_val; never narrower than 1 bit
  // so a zero-wait configuration still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sys_mem_array.sv
// sys_mem_array: single-port synchronous RAM backing the Sys bus responder.
// The read is registered: rdata_o reflects the word addressed on the previous
// rising edge. A write and a read of the same address on one edge return the
// old contents (the responder never relies on that case).
// Contents are never reset.
//
// Ports:
//   clk_i    system clock, rising edge
//   we_i     write enable, stores wdata_i at addr_i on the rising edge
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  registered read data
module sys_mem_array
  import sys_mem_responder_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = SYS_DW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sys_mem_responder.sv
// sys_mem_responder: memory-side responder of the Sys bus driven by the cache
// controller.
//   - Write (SysRW = 0): one word is stored, acknowledged by a single SysReady
//     pulse after WAIT_STATES idle cycles.
//   - Read (SysRW = 1): a whole 2**OFS_W-word block is streamed from offset 0,
//     one SysReady-qualified beat per (WAIT_STATES + 1) cycles.
// Requests never overlap: strobes outside IDLE (including the final SysReady
// cycle) are dropped.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   SysStrobe    one-cycle request strobe
//   SysRW        1 = block read, 0 = single-word write
//   SysAddress   byte address (bits [1:0] and above MEM_AW+1 ignored)
//   SysData_in   write data
//   SysData_out  read beat data, forced to 0 whenever SysReady = 0
//   SysReady     one-cycle beat / acknowledge pulse
module sys_mem_responder
  import sys_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned WAIT_STATES = WAITSTATE,
  parameter int unsigned OFS_W       = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                SysStrobe,
  input  logic                SysRW,
  input  logic [31:0]         SysAddress,
  input  logic [SYS_DW-1:0]   SysData_in,
  output logic [SYS_DW-1:0]   SysData_out,
  output logic                SysReady
);

  localparam int unsigned   WaitW     = cnt_width(WAIT_STATES);
  localparam logic [WaitW-1:0] WaitLoad = WaitW'(WAIT_STATES);
  // With no wait states, a beat follows the request (or the previous beat)
  // directly.
  localparam logic [1:0]    StAfterReq = (WAIT_STATES == 0) ? StBeat : StWait;
  localparam logic [OFS_W-1:0] LastBeat = {OFS_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [OFS_W-1:0]  beat_q, beat_d;
  logic              rw_q, rw_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [SYS_DW-1:0] data_q, data_d;

  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [SYS_DW-1:0] mem_rdata;

  // Address bits outside the word index are deliberately dropped (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{SysAddress[31:MEM_AW+2], SysAddress[1:0]};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;

    case (state_q)
      StIdle: begin
        if (SysStrobe) begin
          rw_d    = SysRW;
          addr_d  = SysAddress[MEM_AW+1:2];
          data_d  = SysData_in;
          wait_d  = WaitLoad;
          beat_d  = '0;
          state_d = StAfterReq;
        end
      end

      StWait: begin
        wait_d = wait_q - WaitW'(1);
        // Counter value 1 marks the last wait cycle.
        if (wait_q <= WaitW'(1)) begin
          state_d = StBeat;
        end
      end

      StBeat: begin
        if (rw_q == RW_WRITE) begin
          state_d = StIdle;
        end else begin
          beat_d = beat_q + OFS_W'(1);
          if (beat_q == LastBeat) begin
            state_d = StIdle;
          end else begin
            wait_d  = WaitLoad;
            state_d = StAfterReq;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
      beat_q  <= '0;
      rw_q    <= RW_WRITE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory interface
  // ---------------------------------------------------------------------------
  // The RAM read is registered, so the address of the next beat is driven from
  // next-state values: it is presented in the cycle before the beat and held
  // through any wait cycles. In a write BEAT the port is used for the store.
  assign mem_we   = (state_q == StBeat) && (rw_q == RW_WRITE);
  assign mem_addr = mem_we ? addr_q : {addr_d[MEM_AW-1:OFS_W], beat_d};

  sys_mem_array #(
    .AW (MEM_AW),
    .DW (SYS_DW)
  ) u_mem_array (
    .clk_i   (clock),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (data_q),
    .rdata_o (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign SysReady    = (state_q == StBeat);
  assign SysData_out = (SysReady && (rw_q == RW_READ)) ? mem_rdata : '0;

endmodule

// File: tb/tb_sys_mem_responder.sv
// Directed bench for sys_mem_responder. Two instances share the clock and
// reset: u_dut_ws2 (WAIT_STATES = 2) and u_dut_ws0 (WAIT_STATES = 0).
// Expected values are hand constants plus a small per-instance write model.
module tb_sys_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        strobe2 = 1'b0;
  logic        strobe0 = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rdy2, rdy0;
  logic [31:0] dout2, dout0;

  int          sel = 0;
  logic        cur_rdy;
  logic [31:0] cur_dat;
  assign cur_rdy = (sel == 1) ? rdy0 : rdy2;
  assign cur_dat = (sel == 1) ? dout0 : dout2;

  logic [31:0] model [2][1024];
  logic        vld   [2][1024];
  logic [31:0] got   [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sys_mem_responder #(
    .MEM_AW      (10),
    .WAIT_STATES (2),
    .OFS_W       (4)
  ) u_dut_ws2 (
    .clock       (clock),
    .reset       (reset),
    .SysStrobe   (strobe2),
    .SysRW       (rw),
    .SysAddress  (addr),
    .SysData_in  (wdata),
    .SysData_out (dout2),
    .SysReady    (rdy2)
  );

  sys_mem_responder #(
    .MEM_AW      (10),
    .WAIT_STATES (0),
    .OFS_W       (4)
  ) u_dut_ws0 (
    .clock       (clock),
    .reset       (reset),
    .SysStrobe   (strobe0),
    .SysRW       (rw),
    .SysAddress  (addr),
    .SysData_in  (wdata),
    .SysData_out (dout0),
    .SysReady    (rdy0)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_strobe(input int s, input logic v);
    if (s == 1) strobe0 = v;
    else        strobe2 = v;
  endtask

  // Strobe a write now (cycle 0); returns in the acknowledge cycle.
  task automatic do_write(input int s, input logic [31:0] a, input logic [31:0] d,
                          input string tag);
    int ws;
    ws  = (s == 1) ? 0 : 2;
    sel = s;
    rw  = 1'b0;
    addr  = a;
    wdata = d;
    set_strobe(s, 1'b1);
    for (int c = 1; c <= ws + 1; c++) begin
      step();
      set_strobe(s, 1'b0);
      check_eq({tag, "_rdy"}, {31'b0, cur_rdy}, (c == ws + 1) ? 32'd1 : 32'd0);
      check_eq({tag, "_dout"}, cur_dat, 32'h0);
    end
    model[s][a[11:2]] = d;
    vld[s][a[11:2]]   = 1'b1;
  endtask

  // Strobe a block read now (cycle 0); returns one cycle after the last beat.
  // busy_beat >= 0 pulses a write strobe to busy_addr during that beat.
  task automatic do_read(input int s, input logic [31:0] a, input string tag,
                         input int busy_beat, input logic [31:0] busy_addr);
    int ws;
    int k;
    logic [9:0] idx;
    ws  = (s == 1) ? 0 : 2;
    k   = 0;
    sel = s;
    rw  = 1'b1;
    addr = a;
    set_strobe(s, 1'b1);
    for (int c = 1; c <= 16 * (ws + 1); c++) begin
      step();
      set_strobe(s, 1'b0);
      if ((c % (ws + 1)) == 0) begin
        check_eq({tag, "_beat_rdy"}, {31'b0, cur_rdy}, 32'd1);
        got[k] = cur_dat;
        idx = {a[11:6], 4'b0000} + 10'(k);
        if (vld[s][idx]) check_eq({tag, "_beat_model"}, cur_dat, model[s][idx]);
        if (k == busy_beat) begin
          rw    = 1'b0;
          addr  = busy_addr;
          wdata = 32'hBAD0_BAD0;
          set_strobe(s, 1'b1);
        end
        k++;
      end else begin
        check_eq({tag, "_gap_rdy"}, {31'b0, cur_rdy}, 32'd0);
        check_eq({tag, "_gap_dout"}, cur_dat, 32'h0);
      end
    end
    step();
    set_strobe(s, 1'b0);
    check_eq({tag, "_tail_rdy"}, {31'b0, cur_rdy}, 32'd0);
    check_eq({tag, "_tail_dout"}, cur_dat, 32'h0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1024; i++) begin
        model[s][i] = 32'h0;
        vld[s][i]   = 1'b0;
      end
    end

    // Reset state.
    #1;
    check_eq("rst_rdy_ws2", {31'b0, rdy2}, 32'd0);
    check_eq("rst_dout_ws2", dout2, 32'h0);
    check_eq("rst_rdy_ws0", {31'b0, rdy0}, 32'd0);
    check_eq("rst_dout_ws0", dout0, 32'h0);
    repeat (3) step();
    reset = 1'b1;
    step();

    // Write then read (WAIT_STATES = 2).
    do_write(0, 32'h0000_0048, 32'hDEAD_BEEF, "wr48");
    step();
    do_read(0, 32'h0000_0040, "rd40", -1, 32'h0);
    check_eq("rd40_beat2", got[2], 32'hDEAD_BEEF);

    // Fill block 0x100..0x13C with its own addresses.
    for (int i = 0; i < 16; i++) begin
      do_write(0, 32'h100 + 32'(4 * i), 32'h100 + 32'(4 * i), "fill");
      step();
    end

    // Busy strobe during beat 5 of a read must be dropped.
    do_read(0, 32'h0000_0040, "busy", 5, 32'h0000_0108);
    check_eq("busy_beat2", got[2], 32'hDEAD_BEEF);

    // Block alignment: beats start at offset 0; 0x108 unchanged by busy write.
    do_read(0, 32'h0000_0124, "align", -1, 32'h0);
    for (int i = 0; i < 16; i++) begin
      check_eq("align_beat", got[i], 32'h100 + 32'(4 * i));
    end

    // Reset in the middle of a burst (beat 2 is at cycle 9).
    sel  = 0;
    rw   = 1'b1;
    addr = 32'h0000_0100;
    set_strobe(0, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      step();
      set_strobe(0, 1'b0);
    end
    check_eq("mid_burst_rdy", {31'b0, rdy2}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rst_async_rdy", {31'b0, rdy2}, 32'd0);
    check_eq("rst_async_dout", dout2, 32'h0);
    repeat (3) begin
      step();
      check_eq("rst_hold_rdy", {31'b0, rdy2}, 32'd0);
      check_eq("rst_hold_dout", dout2, 32'h0);
    end
    reset = 1'b1;
    do_read(0, 32'h0000_0100, "post_rst", -1, 32'h0);
    check_eq("post_rst_beat3", got[3], 32'h0000_010C);

    // Strobe on the final SysReady cycle is ignored.
    do_write(0, 32'h0000_0200, 32'h55AA_55AA, "ta_wr");
    rw   = 1'b1;
    addr = 32'h0000_0200;
    set_strobe(0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      step();
      set_strobe(0, 1'b0);
      check_eq("ta_ignore_rdy", {31'b0, rdy2}, 32'd0);
    end

    // Aliasing: 0x1008 maps to word 2; read strobed the cycle after the ack.
    do_write(0, 32'h0000_1008, 32'h1111_1111, "alias_wr");
    step();
    do_read(0, 32'h0000_0000, "alias_rd", -1, 32'h0);
    check_eq("alias_beat2", got[2], 32'h1111_1111);

    // WAIT_STATES = 0: ack at cycle 1, 16 back-to-back beats.
    do_write(1, 32'h0000_0048, 32'hCAFE_F00D, "ws0_wr");
    step();
    do_read(1, 32'h0000_0040, "ws0_rd", -1, 32'h0);
    check_eq("ws0_beat2", got[2], 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
